pe_task_scheduler: RTL and testbench



---
 rtl/pe_task_scheduler_pkg.sv | 14 +
 rtl/pe_task_scheduler_min_load_select.sv | 39 +++
 rtl/pe_task_scheduler.sv | 94 +++++++++
 tb/tb_pe_task_scheduler.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/pe_task_scheduler_pkg.sv
// pe_task_scheduler_pkg: shared state encoding, default sizing and index-width helper
package pe_task_scheduler_pkg;
    typedef enum logic {
        SCHED_IDLE     = 1'b0,
        SCHED_DISPATCH = 1'b1
    } sched_state_e;
    localparam int DEF_NUM_PE = 16;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_MAX_OUTSTANDING = 4;
    localparam int DEF_CNT_W = 4;
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/pe_task_scheduler_min_load_select.sv
// pe_task_scheduler_min_load_select: argmin tree over per-PE counts, non-full PEs only, lowest index wins ties
module pe_task_scheduler_min_load_select
    import pe_task_scheduler_pkg::*;
#(
    parameter int NUM_PE = DEF_NUM_PE,
    parameter int CNT_W = DEF_CNT_W,
    parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
    localparam int IW = idx_w(NUM_PE)
) (
    input  logic [NUM_PE*CNT_W-1:0] load_i,
    output logic [IW-1:0]           sel_o,
    output logic                    any_o
);
    localparam int P = 1 << IW;
    logic             v [1:2*P-1];
    logic [CNT_W-1:0] c [1:2*P-1];
    logic [IW-1:0]    x [1:2*P-1];
    genvar i;
    for (i = 0; i < P; i++) begin : g_leaf
        if (i < NUM_PE) begin : g_real
            assign c[P+i] = load_i[i*CNT_W +: CNT_W];
            assign v[P+i] = load_i[i*CNT_W +: CNT_W] < CNT_W'(MAX_OUTSTANDING);
        end else begin : g_pad
            assign c[P+i] = '0;
            assign v[P+i] = 1'b0;
        end
        assign x[P+i] = IW'(i);
    end
    // The right child only wins when strictly lower, so ties keep the lower-index left side.
    for (i = 1; i < P; i++) begin : g_node
        logic r;
        assign r = v[2*i+1] && (!v[2*i] || c[2*i+1] < c[2*i]);
        assign v[i] = v[2*i] | v[2*i+1];
        assign c[i] = r ? c[2*i+1] : c[2*i];
        assign x[i] = r ? x[2*i+1] : x[2*i];
    end
    assign sel_o = x[1];
    assign any_o = v[1];
endmodule

// File: rtl/pe_task_scheduler.sv
// pe_task_scheduler: least-loaded task dispatcher with per-PE credit counters
module pe_task_scheduler
    import pe_task_scheduler_pkg::*;
#(
    parameter int NUM_PE = DEF_NUM_PE,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   task_data,
    input  logic                    task_valid,
    output logic                    task_ready,
    output logic [DATA_WIDTH-1:0]   pe_task_data,
    output logic [NUM_PE-1:0]       pe_task_valid,
    input  logic [NUM_PE-1:0]       pe_task_ready,
    input  logic [NUM_PE-1:0]       pe_task_done,
    output logic [NUM_PE*CNT_W-1:0] pe_load,
    output logic                    busy,
    output logic                    err_underflow
);
    localparam int IW = idx_w(NUM_PE);
    sched_state_e           state_q, state_d;
    logic [IW-1:0]          sel_q, sel_d, best;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic                   ready_q, ready_d, err_q, err_d;
    logic [NUM_PE*CNT_W-1:0] cnt_q, cnt_d;
    logic                   any_now, any_next, accept, hs, inc;
    logic [CNT_W-1:0]       cur;

    pe_task_scheduler_min_load_select #(
        .NUM_PE(NUM_PE),
        .CNT_W(CNT_W),
        .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) u_sel (
        .load_i(cnt_q),
        .sel_o(best),
        .any_o(any_now)
    );

    assign accept = state_q == SCHED_IDLE && task_valid && ready_q && any_now;
    assign hs = state_q == SCHED_DISPATCH && pe_task_ready[sel_q];

    // Next counts: handshake increments, done decrements; a done against an empty counter flags underflow.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        any_next = 1'b0;
        inc = 1'b0;
        cur = '0;
        for (int i = 0; i < NUM_PE; i++) begin
            inc = hs && sel_q == IW'(i);
            cur = cnt_q[i*CNT_W +: CNT_W];
            err_d = err_d | (pe_task_done[i] && !inc && cur == '0);
            cnt_d[i*CNT_W +: CNT_W] = cur + CNT_W'(inc) - CNT_W'(pe_task_done[i] && (inc || cur != '0));
            any_next = any_next | (cnt_d[i*CNT_W +: CNT_W] < CNT_W'(MAX_OUTSTANDING));
        end
    end

    // FSM next state; task_ready is registered from next-cycle counts so it never offers into full PEs.
    always_comb begin
        state_d = accept ? SCHED_DISPATCH : hs ? SCHED_IDLE : state_q;
        sel_d = accept ? best : sel_q;
        data_d = accept ? task_data : data_q;
        ready_d = state_d == SCHED_IDLE && any_next;
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SCHED_IDLE;
            sel_q <= '0;
            data_q <= '0;
            ready_q <= 1'b0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q <= sel_d;
            data_q <= data_d;
            ready_q <= ready_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign task_ready = ready_q;
    assign pe_task_data = data_q;
    assign pe_task_valid = (state_q == SCHED_DISPATCH) ? (NUM_PE'(1) << sel_q) : '0;
    assign pe_load = cnt_q;
    assign busy = state_q == SCHED_DISPATCH || |cnt_q;
    assign err_underflow = err_q;
endmodule

// File: tb/tb_pe_task_scheduler.sv
// tb_pe_task_scheduler: directed and random stimulus checked against a behavioural dispatch model
module tb_pe_task_scheduler;
    localparam int N = 16;
    localparam int W = 32;
    localparam int MAX = 4;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [W-1:0] task_data = '0;
    logic task_valid = 1'b0;
    logic task_ready;
    logic [W-1:0] pe_task_data;
    logic [N-1:0] pe_task_valid;
    logic [N-1:0] pe_task_ready = '0;
    logic [N-1:0] pe_task_done = '0;
    logic [N*CW-1:0] pe_load;
    logic busy;
    logic err_underflow;

    int total = 0;
    int bad = 0;

    int cnt [N];
    bit m_disp, m_ready, m_err;
    int m_sel;
    logic [W-1:0] m_data;

    pe_task_scheduler #(
        .NUM_PE(N), .DATA_WIDTH(W), .MAX_OUTSTANDING(MAX), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .task_data(task_data), .task_valid(task_valid), .task_ready(task_ready),
        .pe_task_data(pe_task_data), .pe_task_valid(pe_task_valid),
        .pe_task_ready(pe_task_ready), .pe_task_done(pe_task_done),
        .pe_load(pe_load), .busy(busy), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        foreach (cnt[i]) cnt[i] = 0;
        m_disp = 0;
        m_ready = 0;
        m_err = 0;
        m_sel = 0;
        m_data = '0;
    endtask

    // One clock edge of the scheduler's rules applied to the current inputs.
    task automatic model_tick();
        bit hs, acc, room;
        int best, nc;
        hs = m_disp && pe_task_ready[m_sel];
        acc = !m_disp && task_valid && m_ready;
        best = -1;
        for (int i = 0; i < N; i++)
            if (cnt[i] < MAX && (best < 0 || cnt[i] < cnt[best])) best = i;
        for (int i = 0; i < N; i++) begin
            nc = cnt[i] + ((hs && m_sel == i) ? 1 : 0);
            if (pe_task_done[i]) begin
                if (nc > 0) nc--;
                else m_err = 1;
            end
            cnt[i] = nc;
        end
        if (acc) begin
            m_disp = 1;
            m_sel = best;
            m_data = task_data;
        end else if (hs) m_disp = 0;
        room = 0;
        foreach (cnt[i]) if (cnt[i] < MAX) room = 1;
        m_ready = !m_disp && room;
    endtask

    task automatic check_all();
        logic [63:0] l;
        bit any;
        l = '0;
        any = 0;
        for (int i = 0; i < N; i++) begin
            l[i*CW +: CW] = CW'(cnt[i]);
            if (cnt[i] != 0) any = 1;
        end
        chk("task_ready", 64'(task_ready), 64'(m_ready));
        chk("pe_task_valid", 64'(pe_task_valid), m_disp ? (64'd1 << m_sel) : 64'd0);
        if (m_disp) chk("pe_task_data", 64'(pe_task_data), 64'(m_data));
        chk("pe_load", 64'(pe_load), l);
        chk("busy", 64'(busy), 64'(m_disp || any));
        chk("err_underflow", 64'(err_underflow), 64'(m_err));
    endtask

    task automatic cycle();
        model_tick();
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        model_reset();
        #1;
        chk("rst_ready", 64'(task_ready), 64'd0);
        chk("rst_valid", 64'(pe_task_valid), 64'd0);
        chk("rst_data", 64'(pe_task_data), 64'd0);
        chk("rst_load", 64'(pe_load), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(err_underflow), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Back-to-back tasks spread one per PE in index order.
        pe_task_ready = '1;
        task_valid = 1'b1;
        for (int k = 0; k < 33; k++) begin
            task_data = $urandom;
            cycle();
        end
        task_valid = 1'b0;
        chk("spread_load", 64'(pe_load), 64'h1111_1111_1111_1111);

        // Fill every PE, then a single done reopens exactly that PE.
        task_valid = 1'b1;
        for (int k = 0; k < 96; k++) begin
            task_data = $urandom;
            cycle();
        end
        for (int k = 0; k < 5; k++) cycle();
        chk("full_ready", 64'(task_ready), 64'd0);
        chk("full_load", 64'(pe_load), 64'h4444_4444_4444_4444);
        pe_task_done = N'(1) << 7;
        cycle();
        pe_task_done = '0;
        chk("reopen_ready", 64'(task_ready), 64'd1);
        task_data = 32'hCAFE_0007;
        cycle();
        chk("reopen_pe7", 64'(pe_task_valid), 64'h80);
        cycle();

        // Stall the dispatch to PE3 while unrelated ready bits toggle.
        pe_task_ready = N'($urandom) & ~N'(8);
        pe_task_done = N'(1) << 3;
        cycle();
        pe_task_done = '0;
        task_data = 32'h5EED_0003;
        cycle();
        task_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            pe_task_ready = N'($urandom) & ~N'(8);
            cycle();
        end
        chk("stall_data", 64'(pe_task_data), 64'h5EED_0003);
        chk("stall_load3", 64'(pe_load[3*CW +: CW]), 64'd3);
        pe_task_ready = N'(8);
        cycle();
        chk("stall_done_load3", 64'(pe_load[3*CW +: CW]), 64'd4);

        // Handshake and done on the same PE cancel; done on an empty PE is an error.
        pe_task_done = N'(1) << 2;
        cycle();
        cycle();
        pe_task_done = '0;
        pe_task_ready = '0;
        task_valid = 1'b1;
        task_data = $urandom;
        cycle();
        task_valid = 1'b0;
        chk("sel_pe2", 64'(pe_task_valid), 64'h4);
        pe_task_ready = N'(1) << 2;
        pe_task_done = N'(1) << 2;
        cycle();
        pe_task_done = '0;
        chk("cancel_load2", 64'(pe_load[2*CW +: CW]), 64'd2);
        pe_task_done = N'(1) << 5;
        for (int k = 0; k < 4; k++) cycle();
        chk("pre_err", 64'(err_underflow), 64'd0);
        cycle();
        pe_task_done = '0;
        chk("underflow_load5", 64'(pe_load[5*CW +: CW]), 64'd0);
        chk("underflow_err", 64'(err_underflow), 64'd1);
        cycle();
        cycle();
        chk("underflow_sticky", 64'(err_underflow), 64'd1);

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            task_valid = 1'($urandom);
            task_data = $urandom;
            pe_task_ready = N'($urandom);
            pe_task_done = N'($urandom & $urandom & $urandom);
            cycle();
        end

        // Reset in the middle of a dispatch.
        pe_task_done = '1;
        cycle();
        pe_task_done = '0;
        pe_task_ready = '0;
        task_valid = 1'b1;
        for (int k = 0; k < 20 && !m_disp; k++) cycle();
        chk("reach_dispatch", 64'(|pe_task_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("arst_valid", 64'(pe_task_valid), 64'd0);
        chk("arst_load", 64'(pe_load), 64'd0);
        chk("arst_ready", 64'(task_ready), 64'd0);
        chk("arst_err", 64'(err_underflow), 64'd0);
        task_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle();
        chk("post_rst_ready", 64'(task_ready), 64'd1);

        for (int k = 0; k < 100; k++) begin
            task_valid = 1'($urandom);
            task_data = $urandom;
            pe_task_ready = N'($urandom);
            pe_task_done = N'($urandom & $urandom & $urandom);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
